// File: rtl/even_issue_if.sv
// Bundle between the decode/RF stage and the even-pipe issue stage: the incoming
// instruction, operand sources, pipe forwarding/writeback, and the registered issue outputs.
interface even_issue_if;
  logic               in_valid;
  logic               in_ready;
  logic [10:0]        in_op;
  logic [2:0]         in_format;
  logic [1:0]         in_unit;
  logic               in_fp_int;
  logic [6:0]         in_rt_addr;
  logic [6:0]         in_ra_addr;
  logic [6:0]         in_rb_addr;
  logic [6:0]         in_rc_addr;
  logic               in_use_ra;
  logic               in_use_rb;
  logic               in_use_rc;
  logic [17:0]        in_imm;
  logic               in_reg_write;
  logic [127:0]       rf_ra;
  logic [127:0]       rf_rb;
  logic [127:0]       rf_rc;
  logic [6:0][127:0]  fw_wb;
  logic [6:0][6:0]    fw_addr_wb;
  logic [6:0]         fw_write_wb;
  logic [127:0]       rt_wb;
  logic [6:0]         rt_addr_wb;
  logic               reg_write_wb;
  logic               branch_taken;
  logic [10:0]        op;
  logic [2:0]         format;
  logic [1:0]         unit;
  logic [6:0]         rt_addr;
  logic [17:0]        imm;
  logic               reg_write;
  logic [127:0]       ra;
  logic [127:0]       rb;
  logic [127:0]       rc;
  logic [15:0]        stall_count;

  modport master (
    output in_valid, in_op, in_format, in_unit, in_fp_int, in_rt_addr,
           in_ra_addr, in_rb_addr, in_rc_addr, in_use_ra, in_use_rb, in_use_rc,
           in_imm, in_reg_write, rf_ra, rf_rb, rf_rc, fw_wb, fw_addr_wb,
           fw_write_wb, rt_wb, rt_addr_wb, reg_write_wb, branch_taken,
    input  in_ready, op, format, unit, rt_addr, imm, reg_write, ra, rb, rc,
           stall_count
  );

  modport slave (
    input  in_valid, in_op, in_format, in_unit, in_fp_int, in_rt_addr,
           in_ra_addr, in_rb_addr, in_rc_addr, in_use_ra, in_use_rb, in_use_rc,
           in_imm, in_reg_write, rf_ra, rf_rb, rf_rc, fw_wb, fw_addr_wb,
           fw_write_wb, rt_wb, rt_addr_wb, reg_write_wb, branch_taken,
    output in_ready, op, format, unit, rt_addr, imm, reg_write, ra, rb, rc,
           stall_count
  );
endinterface

// File: rtl/even_issue_stage.sv
// Even-pipe RF/FWD issue stage: scoreboard-based RAW stall, operand forwarding and
// registration of the instruction into the execution pipe.
module even_issue_stage #(
  parameter int LAT_FX1    = 2,
  parameter int LAT_FX2    = 4,
  parameter int LAT_BYTE   = 4,
  parameter int LAT_FP     = 6,
  parameter int LAT_FP_INT = 7,
  parameter int SB_DEPTH   = 8
) (
  input logic         clk,
  input logic         reset,
  even_issue_if.slave bus
);
  localparam int DATA_W = 128;
  localparam int LW     = $clog2(SB_DEPTH + 1) + 1;

  logic [SB_DEPTH-1:0] sb_vld_q;
  logic [6:0]          sb_addr_q [SB_DEPTH];
  logic [LW-1:0]       sb_lat_q  [SB_DEPTH];

  logic              hazard;
  logic              issue;
  logic [10:0]       op_q, op_d;
  logic [2:0]        format_q, format_d;
  logic [1:0]        unit_q, unit_d;
  logic [6:0]        rt_addr_q, rt_addr_d;
  logic [17:0]       imm_q, imm_d;
  logic              reg_write_q, reg_write_d;
  logic [DATA_W-1:0] ra_q, ra_d, rb_q, rb_d, rc_q, rc_d;
  logic [15:0]       stall_q, stall_d;

  function automatic logic [LW-1:0] lat_of(input logic [1:0] u, input logic fp_int);
    case (u)
      2'd0:    lat_of = fp_int ? LW'(LAT_FP_INT) : LW'(LAT_FP);
      2'd1:    lat_of = LW'(LAT_FX2);
      2'd2:    lat_of = LW'(LAT_BYTE);
      default: lat_of = LW'(LAT_FX1);
    endcase
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Forwarding stage 1 is youngest, so the lowest matching stage wins over writeback and RF.
  function automatic logic [DATA_W-1:0] resolve(
    input logic [6:0]             a,
    input logic [DATA_W-1:0]      rf,
    input logic [6:0][DATA_W-1:0] fw,
    input logic [6:0][6:0]        fa,
    input logic [6:0]             fv,
    input logic [DATA_W-1:0]      wb,
    input logic [6:0]             wa,
    input logic                   wv
  );
    logic [DATA_W-1:0] r;
    r = rf;
    if (wv && (wa == a)) r = wb;
    for (int j = 6; j >= 1; j--) begin
      if (fv[j] && (fa[j] == a)) r = fw[j];
    end
    return r;
  endfunction

  // Hazard is qualified by in_valid so an idle input never reports not-ready.
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      if (sb_vld_q[i] && (LW'(i + 1) < sb_lat_q[i])) begin
        if ((bus.in_use_ra && (bus.in_ra_addr == sb_addr_q[i])) ||
            (bus.in_use_rb && (bus.in_rb_addr == sb_addr_q[i])) ||
            (bus.in_use_rc && (bus.in_rc_addr == sb_addr_q[i])))
          hazard = 1'b1;
      end
    end
    hazard = hazard & bus.in_valid;
  end

  assign issue        = bus.in_valid & ~hazard & ~bus.branch_taken;
  assign bus.in_ready = ~(hazard | bus.branch_taken);

  always_comb begin
    op_d        = '0;
    format_d    = '0;
    unit_d      = '0;
    rt_addr_d   = '0;
    imm_d       = '0;
    reg_write_d = 1'b0;
    ra_d        = '0;
    rb_d        = '0;
    rc_d        = '0;
    if (issue) begin
      op_d        = bus.in_op;
      format_d    = bus.in_format;
      unit_d      = bus.in_unit;
      rt_addr_d   = bus.in_rt_addr;
      imm_d       = bus.in_imm;
      reg_write_d = bus.in_reg_write;
      ra_d = bus.in_use_ra ? resolve(bus.in_ra_addr, bus.rf_ra, bus.fw_wb, bus.fw_addr_wb,
                                     bus.fw_write_wb, bus.rt_wb, bus.rt_addr_wb,
                                     bus.reg_write_wb) : bus.rf_ra;
      rb_d = bus.in_use_rb ? resolve(bus.in_rb_addr, bus.rf_rb, bus.fw_wb, bus.fw_addr_wb,
                                     bus.fw_write_wb, bus.rt_wb, bus.rt_addr_wb,
                                     bus.reg_write_wb) : bus.rf_rb;
      rc_d = bus.in_use_rc ? resolve(bus.in_rc_addr, bus.rf_rc, bus.fw_wb, bus.fw_addr_wb,
                                     bus.fw_write_wb, bus.rt_wb, bus.rt_addr_wb,
                                     bus.reg_write_wb) : bus.rf_rc;
    end
    stall_d = (bus.in_valid && hazard && !bus.branch_taken) ? sat_inc16(stall_q) : stall_q;
  end

  // Issue register stage; a branch only injects a bubble, the scoreboard keeps shifting.
  always_ff @(posedge clk) begin
    if (reset) begin
      sb_vld_q    <= '0;
      stall_q     <= '0;
      op_q        <= '0;
      format_q    <= '0;
      unit_q      <= '0;
      rt_addr_q   <= '0;
      imm_q       <= '0;
      reg_write_q <= 1'b0;
      ra_q        <= '0;
      rb_q        <= '0;
      rc_q        <= '0;
    end else begin
      sb_vld_q    <= {sb_vld_q[SB_DEPTH-2:0], issue & bus.in_reg_write};
      stall_q     <= stall_d;
      op_q        <= op_d;
      format_q    <= format_d;
      unit_q      <= unit_d;
      rt_addr_q   <= rt_addr_d;
      imm_q       <= imm_d;
      reg_write_q <= reg_write_d;
      ra_q        <= ra_d;
      rb_q        <= rb_d;
      rc_q        <= rc_d;
    end
  end

  always_ff @(posedge clk) begin
    sb_addr_q[0] <= bus.in_rt_addr;
    sb_lat_q[0]  <= lat_of(bus.in_unit, bus.in_fp_int);
    for (int i = 1; i < SB_DEPTH; i++) begin
      sb_addr_q[i] <= sb_addr_q[i-1];
      sb_lat_q[i]  <= sb_lat_q[i-1];
    end
  end

  assign bus.op          = op_q;
  assign bus.format      = format_q;
  assign bus.unit        = unit_q;
  assign bus.rt_addr     = rt_addr_q;
  assign bus.imm         = imm_q;
  assign bus.reg_write   = reg_write_q;
  assign bus.ra          = ra_q;
  assign bus.rb          = rb_q;
  assign bus.rc          = rc_q;
  assign bus.stall_count = stall_q;
endmodule

// File: tb/tb_even_issue_stage.sv
// Scoreboard bench for even_issue_stage: register-availability reference model, directed
// hazard scenarios, then randomized traffic with flushes and resets.
module tb_even_issue_stage;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  even_issue_if bus();
  even_issue_stage dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    logic [10:0]  op;
    logic [2:0]   fmt;
    logic [1:0]   unit;
    logic [6:0]   rt;
    logic [17:0]  imm;
    logic         rw;
    logic [127:0] ra, rb, rc;
    logic [15:0]  stall;
  } exp_t;

  exp_t        expq[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          rdy[128];
  logic [15:0] stall_m = '0;

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, got, want);
    end
  endtask

  function automatic int lat_m(input logic [1:0] u, input logic fpi);
    if (u == 2'd0) return fpi ? 7 : 6;
    if (u == 2'd3) return 2;
    return 4;
  endfunction

  function automatic logic [127:0] res_m(input logic use_x, input logic [6:0] a,
                                         input logic [127:0] rf);
    if (!use_x) return rf;
    for (int j = 1; j <= 6; j++)
      if (bus.fw_write_wb[j] && bus.fw_addr_wb[j] == a) return bus.fw_wb[j];
    if (bus.reg_write_wb && bus.rt_addr_wb == a) return bus.rt_wb;
    return rf;
  endfunction

  // One clock: predict, check readiness, queue expected outputs, advance the model.
  task automatic step(input bit rst_v, output bit acc);
    bit   hz, er, iss;
    exp_t e;
    int   l;
    reset = rst_v;
    #1;
    hz = bus.in_valid && ((bus.in_use_ra && cyc < rdy[bus.in_ra_addr]) ||
                          (bus.in_use_rb && cyc < rdy[bus.in_rb_addr]) ||
                          (bus.in_use_rc && cyc < rdy[bus.in_rc_addr]));
    er  = !hz && !bus.branch_taken;
    iss = bus.in_valid && er;
    chk("in_ready", bus.in_ready, er);
    acc = bus.in_valid && bus.in_ready && !rst_v;
    e = '{default: '0};
    if (!rst_v && iss) begin
      e.op = bus.in_op; e.fmt = bus.in_format; e.unit = bus.in_unit;
      e.rt = bus.in_rt_addr; e.imm = bus.in_imm; e.rw = bus.in_reg_write;
      e.ra = res_m(bus.in_use_ra, bus.in_ra_addr, bus.rf_ra);
      e.rb = res_m(bus.in_use_rb, bus.in_rb_addr, bus.rf_rb);
      e.rc = res_m(bus.in_use_rc, bus.in_rc_addr, bus.rf_rc);
    end
    if (rst_v) stall_m = '0;
    else if (bus.in_valid && hz && !bus.branch_taken && stall_m != 16'hFFFF) stall_m++;
    e.stall = stall_m;
    expq.push_back(e);
    @(posedge clk);
    if (rst_v) begin
      foreach (rdy[k]) rdy[k] = 0;
    end else if (iss && bus.in_reg_write) begin
      l = cyc + lat_m(bus.in_unit, bus.in_fp_int);
      if (l > rdy[bus.in_rt_addr]) rdy[bus.in_rt_addr] = l;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic set_instr(input logic [1:0] u, input logic fpi, input logic [6:0] rt,
                           input logic [6:0] a, input logic [6:0] b, input logic [6:0] c,
                           input logic [2:0] uses, input logic rw);
    bus.in_valid = 1'b1; bus.in_op = 11'($urandom); bus.in_format = 3'($urandom);
    bus.in_imm = 18'($urandom); bus.in_unit = u; bus.in_fp_int = fpi;
    bus.in_rt_addr = rt; bus.in_ra_addr = a; bus.in_rb_addr = b; bus.in_rc_addr = c;
    bus.in_use_ra = uses[0]; bus.in_use_rb = uses[1]; bus.in_use_rc = uses[2];
    bus.in_reg_write = rw;
  endtask

  task automatic quiet_env();
    bus.rf_ra = {4{$urandom}}; bus.rf_rb = {4{$urandom}}; bus.rf_rc = {4{$urandom}};
    for (int j = 0; j < 7; j++) begin
      bus.fw_wb[j] = {4{$urandom}}; bus.fw_addr_wb[j] = 7'($urandom_range(0, 127));
    end
    bus.fw_write_wb = '0; bus.rt_wb = {4{$urandom}}; bus.rt_addr_wb = '0;
    bus.reg_write_wb = 1'b0; bus.branch_taken = 1'b0;
  endtask

  task automatic rand_env();
    quiet_env();
    for (int j = 0; j < 7; j++) bus.fw_addr_wb[j] = 7'($urandom_range(0, 7));
    bus.fw_write_wb = 7'($urandom);
    bus.rt_addr_wb = 7'($urandom_range(0, 7));
    bus.reg_write_wb = 1'($urandom);
  endtask

  task automatic run_until(input string nm, input int want);
    int w = 0;
    bit a = 1'b0;
    while (!a && w < 30) begin
      step(1'b0, a);
      if (!a) w++;
    end
    if (!a) chk({nm, "_timeout"}, 1'b0, 1'b1);
    chk(nm, w, want);
  endtask

  task automatic do_reset();
    bit a;
    bus.in_valid = 1'b0;
    quiet_env();
    step(1'b1, a);
  endtask

  // Outputs settle after the edge and are compared 1 time unit later.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("op", bus.op, e.op);
        chk("format", bus.format, e.fmt);
        chk("unit", bus.unit, e.unit);
        chk("rt_addr", bus.rt_addr, e.rt);
        chk("imm", bus.imm, e.imm);
        chk("reg_write", bus.reg_write, e.rw);
        chk("ra", bus.ra, e.ra);
        chk("rb", bus.rb, e.rb);
        chk("rc", bus.rc, e.rc);
        chk("stall_count", bus.stall_count, e.stall);
      end
    end
  end

  initial begin
    bit a, pend;
    int w;
    foreach (rdy[k]) rdy[k] = 0;
    reset = 1'b1;
    bus.in_valid = 1'b0;
    set_instr(2'd0, 1'b0, 7'd0, 7'd0, 7'd0, 7'd0, 3'b000, 1'b0);
    bus.in_valid = 1'b0;
    quiet_env();
    @(negedge clk);
    do_reset();
    do_reset();

    // FX1 r5 -> dependent FX1: one bubble, ra from forwarding stage 1.
    set_instr(2'd3, 1'b0, 7'd5, 7'd1, 7'd2, 7'd3, 3'b000, 1'b1);
    step(1'b0, a);
    set_instr(2'd3, 1'b0, 7'd6, 7'd5, 7'd2, 7'd3, 3'b001, 1'b1);
    bus.fw_write_wb[1] = 1'b1; bus.fw_addr_wb[1] = 7'd5;
    run_until("fx1_stalls", 1);
    chk("fx1_stall_count_model", stall_m, 16'd1);

    // FP r10 -> FX2 reading rb: five stalls, rb from a later forwarding stage.
    do_reset();
    set_instr(2'd0, 1'b0, 7'd10, 7'd1, 7'd2, 7'd3, 3'b000, 1'b1);
    step(1'b0, a);
    set_instr(2'd1, 1'b0, 7'd11, 7'd1, 7'd10, 7'd3, 3'b010, 1'b1);
    bus.fw_write_wb[4] = 1'b1; bus.fw_addr_wb[4] = 7'd10;
    run_until("fp_stalls", 5);

    // FP integer r3 -> Byte reading rc: six stalls, rc from writeback over RF.
    do_reset();
    set_instr(2'd0, 1'b1, 7'd3, 7'd1, 7'd2, 7'd4, 3'b000, 1'b1);
    step(1'b0, a);
    set_instr(2'd2, 1'b0, 7'd12, 7'd1, 7'd2, 7'd3, 3'b100, 1'b1);
    bus.rf_rc = 128'hDEAD; bus.reg_write_wb = 1'b1; bus.rt_addr_wb = 7'd3;
    run_until("fpint_stalls", 6);

    // Eight independent FX2 ops: no stalls at all.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      set_instr(2'd1, 1'b0, 7'(20 + i), 7'(40 + i), 7'(50 + i), 7'(60 + i), 3'b111, 1'b1);
      run_until("indep_stalls", 0);
    end

    // Consumer of r7 with a one-cycle flush during the stall: same issue age.
    do_reset();
    set_instr(2'd0, 1'b0, 7'd7, 7'd1, 7'd2, 7'd3, 3'b000, 1'b1);
    step(1'b0, a);
    set_instr(2'd1, 1'b0, 7'd8, 7'd7, 7'd2, 7'd3, 3'b001, 1'b1);
    w = 0;
    step(1'b0, a); w++;
    bus.branch_taken = 1'b1;
    step(1'b0, a); w++;
    bus.branch_taken = 1'b0;
    a = 1'b0;
    while (!a && w < 30) begin
      step(1'b0, a);
      if (!a) w++;
    end
    chk("branch_stalls", w, 5);
    chk("branch_stall_count_model", stall_m, 16'd4);

    // Reset in the middle of a stall: the held consumer then issues at once from RF.
    do_reset();
    set_instr(2'd0, 1'b1, 7'd9, 7'd1, 7'd2, 7'd3, 3'b000, 1'b1);
    step(1'b0, a);
    set_instr(2'd3, 1'b0, 7'd13, 7'd9, 7'd9, 7'd9, 3'b111, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, a);
    step(1'b1, a);
    run_until("post_reset_stalls", 0);

    // Randomized traffic with holds, flushes and occasional resets.
    pend = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      bit r;
      if (!pend) begin
        set_instr(2'($urandom), 1'($urandom), 7'($urandom_range(0, 7)),
                  7'($urandom_range(0, 7)), 7'($urandom_range(0, 7)),
                  7'($urandom_range(0, 7)), 3'($urandom), ($urandom_range(0, 9) < 8));
        bus.in_valid = ($urandom_range(0, 99) < 85);
      end
      rand_env();
      bus.branch_taken = ($urandom_range(0, 9) == 0);
      r = ($urandom_range(0, 199) == 0);
      step(r, a);
      pend = bus.in_valid && !a && !r;
    end

    bus.in_valid = 1'b0;
    quiet_env();
    step(1'b0, a);
    step(1'b0, a);
    chk("queue_drained", expq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/even_issue_stage.md
Name: even_issue_stage

Overview:
- RF/FWD stage directly upstream of the even execution pipe.
- Accepts one decoded even-pipe instruction per cycle plus register-file operand values.
- Detects RAW hazards against in-flight even-pipe writes using an internal scoreboard, and stalls the upstream source with a bubble until every operand is forwardable.
- Resolves operands from the pipe's forwarding stages, its writeback, or the register file, then registers the instruction into the execution pipe.

Parameters:
LAT_FX1, 2, cycles from issue until an FX1 result is forwardable
LAT_FX2, 4, same for FX2
LAT_BYTE, 4, same for Byte
LAT_FP, 6, same for FP float result
LAT_FP_INT, 7, same for FP integer result (writeback only)
SB_DEPTH, 8, scoreboard entries; must be >= LAT_FP_INT

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
in_valid  in  1  decoded instruction present
in_ready  out  1  instruction accepted this cycle
in_op  in  11  decoded opcode
in_format  in  3  instruction format
in_unit  in  2  0 FP, 1 FX2, 2 Byte, 3 FX1
in_fp_int  in  1  FP op yields integer result (uses LAT_FP_INT)
in_rt_addr  in  7  destination register
in_ra_addr, in_rb_addr, in_rc_addr  in  7 each  source registers
in_use_ra, in_use_rb, in_use_rc  in  1 each  source is read
in_imm  in  18  immediate
in_reg_write  in  1  instruction writes RT
rf_ra, rf_rb, rf_rc  in  128 each  register-file read values
fw_wb  in  7x128  pipe forwarding values, index 0..6
fw_addr_wb  in  7x7  forwarding addresses
fw_write_wb  in  7  forwarding valid
rt_wb, rt_addr_wb, reg_write_wb  in  128/7/1  pipe writeback
branch_taken  in  1  flush younger instructions
op, format, unit, rt_addr, imm, reg_write  out  11/3/2/7/18/1  registered to pipe
ra, rb, rc  out  128 each  registered resolved operands
stall_count  out  16  saturating count of stall cycles

Behaviour:
- Reset: all registered outputs 0, stall_count 0, every scoreboard entry invalid. in_ready is combinational and evaluates to 1 with in_valid=0.
- Scoreboard: SB_DEPTH entries of {valid, addr, lat}. Each cycle it shifts, entry i moving to entry i+1 and the last entry dropping. Entry 0 loads the instruction issued at this edge; a bubble loads valid=0. Age of entry i is i+1.
- Latency of an entry: lat = LAT_FP_INT if unit=0 and fp_int=1; otherwise the per-unit LAT_*. Entry valid = in_reg_write of the issued instruction.
- Hazard: any used source equals the addr of a valid entry with age < lat.
- Issue condition: in_valid and no hazard and no branch_taken. When met, in_ready=1, and at the edge all outputs load the instruction fields plus the resolved operands.
- Stall or empty: in_ready=0 when hazard or branch_taken. Outputs load a bubble: op=0, format=0, unit=0, rt_addr=0, imm=0, reg_write=0, ra/rb/rc=0.
- stall_count increments on each cycle with in_valid=1, hazard=1 and no branch_taken. It saturates at 0xFFFF.
- branch_taken=1: input is not accepted and a bubble is issued. Scoreboard contents are retained, because older instructions still complete.
- Operand resolution for each source, highest priority first:
  - fw_wb[j] for the lowest j in 1..6 with fw_write_wb[j]=1 and a matching fw_addr_wb[j];
  - then rt_wb when reg_write_wb=1 and rt_addr_wb matches;
  - then rf_x.
  - Unused sources (in_use_x=0) still pass rf_x.
- Simultaneous hazard on several sources: a single stall is taken, and issue happens once all hazards clear.
- in_rt_addr equal to a source address is legal; the scoreboard only blocks on older entries.
- Reset mid-stall: the held request is dropped, the scoreboard is cleared, and the next cycle has no hazard.

Test Plan:
- FX1 writes r5, then dependent FX1 reads r5, back-to-back: one bubble cycle (age 1 < 2). Second issue on cycle 2 with ra taken from fw_wb[1] matched to r5. stall_count=1.
- FP (fp_int=0) writes r10, then FX2 reads r10 as rb: 5 stall cycles. Issue at age 6, rb from the matching fw stage. stall_count=5.
- FP int writes r3, then Byte reads r3 as rc: 6 stalls. rc sourced from rt_wb/reg_write_wb matching r3, not from rf_rc=0xDEAD.
- No dependency: 8 consecutive independent FX2 ops, each with in_valid=1. in_ready=1 every cycle, zero bubbles, stall_count=0.
- Stalled consumer of r7 while branch_taken pulses for 1 cycle: bubble issued and stall_count unchanged that cycle. Scoreboard keeps r7 pending and issue occurs at the same age as without the flush.
- Reset asserted during a 4-cycle stall: next cycle all outputs 0, and the previously hazardous instruction presented again issues immediately using rf values.
